// File: rtl/adc_4ch_axis_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_4ch_axis_packer
// Purpose  : Captures decimated 4-channel ADC sample sets into fixed-length
//            frames. Each set becomes one 64-bit AXI4-Stream word (lane A in
//            [15:0], each lane sign-extended to 16 bits). A small FWFT FIFO
//            absorbs downstream backpressure, and a sticky flag records
//            samples lost to a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module adc_4ch_axis_packer #(
  parameter int DW         = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DW-1:0]    adc_a_i,
  input  logic [DW-1:0]    adc_b_i,
  input  logic [DW-1:0]    adc_c_i,
  input  logic [DW-1:0]    adc_d_i,
  input  logic             adc_vld_i,
  input  logic [15:0]      cfg_dec_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             ovf_clr_i,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy_o,
  output logic             ovf_o,
  output logic [LEN_W-1:0] smp_cnt_o
);

  localparam int              c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_depth = (c_aw+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_dec;
  logic [15:0]      r_dec_cnt;
  logic [LEN_W-1:0] r_smp_cnt;
  logic             r_ovf;

  logic [64:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;

  logic             w_start;
  logic             w_accept;
  logic             w_is_last;
  logic             w_pop;
  logic             w_room;
  logic             w_push;
  logic             w_drop;
  logic             w_drain_done;
  logic [63:0]      w_word;

  // Widen one two's-complement sample to a 16-bit lane.
  function automatic logic [15:0] sext(input logic [DW-1:0] x);
    logic [15:0] v;
    v         = {16{x[DW-1]}};
    v[DW-1:0] = x;
    return v;
  endfunction

  assign w_word    = {sext(adc_d_i), sext(adc_c_i), sext(adc_b_i), sext(adc_a_i)};

  assign w_start   = (r_state == S_IDLE) && start_i && (cfg_len_i != '0) && !stop_i;
  assign w_accept  = (r_state == S_RUN) && adc_vld_i && (r_dec_cnt == 16'd0);
  assign w_is_last = (r_smp_cnt == (r_len - LEN_W'(1)));
  assign w_pop     = m_axis_tvalid && m_axis_tready;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign w_room    = (r_count != c_depth) || w_pop;
  // A stop only suppresses the push when the word would not have closed the frame.
  assign w_push    = w_accept && w_room && (!stop_i || w_is_last);
  assign w_drop    = w_accept && !w_room && (!stop_i || w_is_last);
  // Drain finishes once the FIFO is empty after this cycle's pop.
  assign w_drain_done = (r_count == '0) || ((r_count == (c_aw+1)'(1)) && w_pop);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if ((w_push && w_is_last) || stop_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame configuration latch, decimation phase and pushed-word count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_len     <= '0;
      r_dec     <= 16'd1;
      r_dec_cnt <= 16'd0;
      r_smp_cnt <= '0;
    end else if (w_start) begin
      r_len     <= cfg_len_i;
      r_dec     <= (cfg_dec_i == 16'd0) ? 16'd1 : cfg_dec_i;
      r_dec_cnt <= 16'd0;
      r_smp_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (adc_vld_i) begin
        r_dec_cnt <= (r_dec_cnt == (r_dec - 16'd1)) ? 16'd0 : (r_dec_cnt + 16'd1);
      end
      if (w_push) begin
        r_smp_cnt <= r_smp_cnt + LEN_W'(1);
      end
    end
  end

  // Sticky overflow; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_is_last, w_word};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_aw'(1);
      if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rptr][63:0] : 64'd0;
  assign m_axis_tlast  = m_axis_tvalid && r_mem[r_rptr][64];
  assign busy_o        = (r_state != S_IDLE);
  assign ovf_o         = r_ovf;
  assign smp_cnt_o     = r_smp_cnt;

endmodule
`default_nettype wire

// File: doc/adc_4ch_axis_packer.md
Name: adc_4ch_axis_packer

Overview:
Captures frames of samples from the four ADC channels and packs each 4-channel sample set into one 64-bit AXI4-Stream word. It sits directly upstream of the PS system block and feeds its DMA/HP slave stream. It provides decimation, a fixed frame length with TLAST on the final word, and a small FWFT FIFO to absorb PS backpressure. Status outputs are busy, a sticky overflow flag and a word count.

Parameters:
DW, 14, ADC sample width (two's complement), 2..16
FIFO_DEPTH, 16, output FIFO entries, power of two >= 2
LEN_W, 16, width of the frame length and word count

Ports:
clk_i  in  1  ADC/system clock
rstn_i  in  1  reset, asynchronous, active-low
adc_a_i  in  DW  channel A sample
adc_b_i  in  DW  channel B sample
adc_c_i  in  DW  channel C sample
adc_d_i  in  DW  channel D sample
adc_vld_i  in  1  all four samples valid this cycle
cfg_dec_i  in  16  decimation factor; 0 treated as 1
cfg_len_i  in  LEN_W  words per frame; 0 = start ignored
start_i  in  1  single-cycle pulse, arm and start a frame
stop_i  in  1  single-cycle pulse, abort capture
ovf_clr_i  in  1  clear sticky overflow
m_axis_tdata  out  64  {sext(D),sext(C),sext(B),sext(A)}, 16 bits each, A in [15:0]
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tlast  out  1  final word of the frame
busy_o  out  1  state != IDLE
ovf_o  out  1  sticky: an accepted sample was dropped because the FIFO was full
smp_cnt_o  out  LEN_W  words pushed in the current or last frame

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, all outputs 0, dec_cnt=0, smp_cnt_o=0, ovf_o=0. Reset mid-frame discards everything, including FIFO contents.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN: start_i=1 and cfg_len_i!=0 and stop_i=0.
  - Latches len=cfg_len_i and dec=max(cfg_dec_i,1).
  - Clears dec_cnt and smp_cnt_o. ovf_o is not cleared.
- IDLE: start_i with cfg_len_i==0 is ignored. start_i together with stop_i stays in IDLE.
- RUN, decimation: on each adc_vld_i, the sample is accepted if dec_cnt==0. dec_cnt then increments and wraps at dec-1. The first valid after start is accepted. adc_vld_i is ignored outside RUN.
- RUN, accepted sample:
  - Pushed if FIFO count<FIFO_DEPTH, or FIFO is full and a pop occurs in the same cycle.
  - On push: smp_cnt_o++. The entry's last bit = (smp_cnt_o==len-1).
  - If not pushed: sample dropped, ovf_o<=1, smp_cnt_o unchanged. Frames therefore always contain exactly len words; ovf_o marks a timing gap.
- RUN -> DRAIN: on the push of the last word, or on stop_i.
  - On stop_i, samples arriving in the same cycle are not pushed.
  - A frame aborted by stop_i ends without TLAST; remaining FIFO words are still delivered.
  - If stop_i and the last push occur in the same cycle, the push happens with TLAST.
- DRAIN -> IDLE: when the FIFO is empty. start_i is ignored in RUN and DRAIN. stop_i in DRAIN has no effect.
- Output FIFO (FWFT):
  - m_axis_tvalid = FIFO non-empty. tdata/tlast come from the head entry.
  - Pop when tvalid&&tready.
  - Latency: a sample accepted at clock edge k gives tvalid=1 after edge k (visible the following cycle) if the FIFO was empty.
  - AXIS rule: once tvalid=1, it and tdata/tlast stay stable until the handshake.
- Sign extension: bits [15:DW] of each lane = sample bit DW-1.
- ovf_o: set has priority over ovf_clr_i in the same cycle.
- smp_cnt_o holds its value in DRAIN and IDLE until the next start.

Test Plan:
- dec=1, len=4, tready=1, A..D = 1,-1,8191,-8192 (DW=14) -> 4 words, first = 0xE000_1FFF_FFFF_0001, tvalid 1 cycle after vld, tlast on word 4 only, busy_o falls after the last pop, smp_cnt_o=4.
- dec=3, len=3, adc_vld_i continuous with incrementing A=0,1,2,... -> lane A words 0,3,6; cfg_dec_i=0 run gives 0,1,2.
- FIFO_DEPTH=16, len=20, dec=1, tready=0 for 30 valid cycles, then 1 -> 16 words buffered, later samples dropped, ovf_o=1; after release the remaining 4 words are pushed from new samples; 20 words total, tlast on the 20th.
- len=10, stop_i after 5 pushes, tready=0 then 1 -> 5 words delivered with no tlast, busy_o drops when empty; start_i in DRAIN ignored.
- start_i with cfg_len_i=0, and start_i+stop_i together -> busy_o stays 0, no output; ovf_clr_i and an overflow event in the same cycle -> ovf_o=1.
- rstn_i asserted mid-frame with 3 words in the FIFO -> tvalid, busy_o, smp_cnt_o, ovf_o go 0 immediately (async); a new frame after release behaves as in the first scenario.
